// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-mux encodings
// and the default register-address width.
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/md_scoreboard.sv
// Busy scoreboard for the multi-cycle mult/div unit: a down-counter loaded
// on launch, exposing busy and the launch-accepted-this-cycle flag.
module md_scoreboard #(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic mdstart_i,
  input  logic stall_e_i,
  output logic mdbusy_o,
  output logic mdload_o
);

  localparam int CW = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY);

  logic [CW-1:0] count_q, count_d;

  // A launch held in E by a memory wait is not accepted until E advances.
  assign mdload_o = mdstart_i && !stall_e_i && !reset;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (mdload_o) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign mdbusy_o = (count_q != '0) && !reset;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Optional stall/flush performance counters are built with HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEFAULT,
  parameter int MD_LATENCY = 32
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             mdstartE,
  input  logic             mdreadD,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             mdbusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stallcycles,
  output logic [CNT_W-1:0] flushcount
`endif
);

  logic memstall, lwstall, branchstall, mdstall, mdload;

  // Register 0 is hardwired, so a match on it never creates a dependency.
  function automatic logic hit(input logic [REG_W-1:0] src,
                               input logic [REG_W-1:0] dst,
                               input logic             wen);
    return wen && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src);
    if (hit(src, writeregM, regwriteM)) return FWD_MEM;
    if (hit(src, writeregW, regwriteW)) return FWD_WB;
    return FWD_NONE;
  endfunction

  assign memstall = memreqM && !memreadyM;

  md_scoreboard #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .mdstart_i (mdstartE),
    .stall_e_i (memstall),
    .mdbusy_o  (mdbusy),
    .mdload_o  (mdload)
  );

  assign lwstall     = hit(rsD, writeregE, memtoregE) || hit(rtD, writeregE, memtoregE);
  assign branchstall = branchD &&
                       (hit(rsD, writeregE, regwriteE) || hit(rtD, writeregE, regwriteE) ||
                        hit(rsD, writeregM, memtoregM) || hit(rtD, writeregM, memtoregM));
  assign mdstall     = mdreadD && (mdbusy || mdload);

  assign forwardaE = reset ? FWD_NONE : fwd_e(rsE);
  assign forwardbE = reset ? FWD_NONE : fwd_e(rtE);
  assign forwardaD = !reset && hit(rsD, writeregM, regwriteM);
  assign forwardbD = !reset && hit(rtD, writeregM, regwriteM);

  // A memory wait freezes the whole front of the pipe and wins over D-stage hazards.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (reset) begin
      flushE = 1'b1;
      flushW = 1'b1;
    end else if (memstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (lwstall || branchstall || mdstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallcycles_q, flushcount_q;

  // Saturating event counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallcycles_q <= '0;
      flushcount_q  <= '0;
    end else begin
      if (stallF && !(&stallcycles_q)) stallcycles_q <= stallcycles_q + CNT_W'(1);
      if (flushE && !(&flushcount_q))  flushcount_q  <= flushcount_q + CNT_W'(1);
    end
  end

  assign stallcycles = stallcycles_q;
  assign flushcount  = flushcount_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipelined MIPS core, instantiated beside the datapath to drive its stage enables and forwarding muxes. It adds decode-stage branch forwarding, branch-compare stalls, a multi-cycle memory wait handshake, and a busy scoreboard for a multi-cycle mult/div unit.

## Interface
- REG_W, 5, register-address width
- MD_LATENCY, 32, cycles the mult/div unit stays busy after launch; must be ≥1
- CNT_W, 32, performance counter width (HAZARD_PERF_EN only)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rsD, rtD, rsE, rtE  in  REG_W  source registers in D and E
- writeregE, writeregM, writeregW  in  REG_W  destination registers
- regwriteE, regwriteM, regwriteW  in  1  register-write enables
- memtoregE, memtoregM  in  1  load in E / M
- branchD  in  1  branch being compared in D
- mdstartE  in  1  E instruction launches mult/div
- mdreadD  in  1  D instruction reads HI/LO or launches mult/div
- memreqM, memreadyM  in  1  data-memory request / ready
- forwardaD, forwardbD  out  1  forward ALUoutM to the D comparator
- forwardaE, forwardbE  out  2  E operand select
- stallF, stallD, stallE, stallM  out  1  hold the stage register
- flushE, flushW  out  1  insert a bubble into the E / W register
- mdbusy  out  1  mult/div counter nonzero
- stallcycles, flushcount  out  CNT_W  each present only with HAZARD_PERF_EN

## Operation
- Register 0 never matches: every comparison below is qualified by the compared register being nonzero.
- forwardaE: 10 when rsE==writeregM and regwriteM; otherwise 01 when rsE==writeregW and regwriteW; otherwise 00. forwardbE is the same using rtE. The M match wins over the W match.
- forwardaD: rsD==writeregM and regwriteM. forwardbD is the same using rtD.
- lwstall: memtoregE and writeregE matches rsD or rtD.
- branchstall: branchD and either of these holds for rsD or rtD:
  - regwriteE and writeregE matches, or
  - memtoregM and writeregM matches.
- mdstall: mdreadD and either count≠0 or a mult/div start is loading this cycle.
- memstall: memreqM and not memreadyM.
- Priority 1, memstall: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0.
- Priority 2, lwstall, branchstall or mdstall: stallF=stallD=flushE=1. stallE, stallM and flushW are 0.
- Otherwise all stall and flush outputs are 0.
- Mult/div counter (width $clog2(MD_LATENCY+1), reset 0):
  - Loads MD_LATENCY when mdstartE and not stallE.
  - Otherwise decrements when nonzero.
  - It keeps decrementing during memstall.
- mdstartE while count≠0 (prevented by mdstall) reloads the counter.
- mdbusy = (count≠0).

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the counter, with zero latency.
- While reset=1:
  - All stalls are 0.
  - flushE=flushW=1.
  - Forward selects are 0.
  - mdbusy=0.
- The counter is cleared at the first clock edge with reset=1. A reset during a mult/div operation aborts the scoreboard.
- A launch at edge t gives mdbusy=1 for exactly MD_LATENCY cycles. A dependent D instruction advances on the first edge after count returns to 0.
- A mdstartE held under memstall does not load the counter. It loads at the edge that releases the stall.
- memreadyM asserted in the same cycle as memreqM produces no stall.
- memstall together with lwstall: memstall outputs only. lwstall re-evaluates after memstall releases.

## Configuration
- HAZARD_PERF_EN defined:
  - stallcycles increments on every non-reset cycle with stallF=1.
  - flushcount increments on every non-reset cycle with flushE=1.
  - Both reset to 0 and saturate at all-ones.
- HAZARD_PERF_EN undefined: the counters and their ports do not exist. Hazard behaviour is identical.

## Structure
- Package hazard_pkg holds the forward encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the default REG_W.
- Sub-module md_scoreboard contains the mult/div counter and produces mdbusy and the load-this-cycle flag.
- Forwarding and stall logic live in hazard_ctrl.

## Test plan
- Forwarding, M over W: rsE=rtE=8, writeregM=writeregW=8, regwriteM=regwriteW=1 → forwardaE=forwardbE=10. Drop regwriteM → 01. Set rsE=0 → 00.
- Load-use: memtoregE=1, writeregE=9, rtD=9 → stallF=stallD=flushE=1, stallE=0. Set writeregE=0 → no stall.
- Branch: branchD=1, rsD=4:
  - regwriteE=1, writeregE=4 → stall.
  - Next cycle, writeregM=4 with regwriteM=1 and memtoregM=0 → no stall, forwardaD=1.
- Mult/div, MD_LATENCY=4:
  - mdstartE pulse → mdbusy high for 4 cycles.
  - mdreadD held → stallD high through those 4 cycles, low on the 5th.
  - Reset on cycle 2 → mdbusy=0 after the edge.
- Memory wait: memreqM=1, memreadyM=0 for 3 cycles, with lwstall also true → all four stalls and flushW=1, flushE=0. memreadyM=1 → lwstall outputs appear.
- Perf (HAZARD_PERF_EN): 5 load-use stall cycles → stallcycles=5, flushcount=5. CNT_W=3 over 9 cycles → both saturate at 7.
